// File: rtl/aes_key_expand_last.sv
// AES-128 forward key schedule, one round per clock.
// Produces round key 10 as the starting key for the decipher datapath.
module aes_key_expand_last (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] cipher_key,
   output logic [127:0] round_key_10,
   output logic         key_ready,
   output logic         busy
);

   typedef enum logic {
      IDLE,
      EXPAND
   } state_e;

   // Forward S-box, byte 0x00 in the top 8 bits.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_e         state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [127:0]   wk_q, wk_d;
   logic [127:0]   rk_q, rk_d;
   logic           kr_q, kr_d;

   logic [31:0]    w0, w1, w2, w3;
   logic [31:0]    temp;
   logic [31:0]    n0, n1, n2, n3;
   logic [127:0]   next_key;

   // Byte b lives at bit offset (255-b)*8, and 255-b is just ~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]),  sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // One key-expansion round applied to the working key.
   always_comb begin
      w0 = wk_q[127:96];
      w1 = wk_q[95:64];
      w2 = wk_q[63:32];
      w3 = wk_q[31:0];
      temp = sub_word({w3[23:0], w3[31:24]})
           ^ {rcon(rnd_q), 24'h0};
      n0 = w0 ^ temp;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // Next-state logic: load on start, iterate, publish after round 10.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      wk_d    = wk_q;
      rk_d    = rk_q;
      kr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               wk_d    = cipher_key;
               rnd_d   = 4'd1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            wk_d = next_key;
            if (rnd_q == 4'd10) begin
               rk_d    = next_key;
               kr_d    = 1'b1;
               rnd_d   = 4'd0;
               state_d = IDLE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rnd_q   <= 4'd0;
         wk_q    <= 128'h0;
         rk_q    <= 128'h0;
         kr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         wk_q    <= wk_d;
         rk_q    <= rk_d;
         kr_q    <= kr_d;
      end
   end

   assign round_key_10 = rk_q;
   assign key_ready    = kr_q;
   assign busy         = (state_q == EXPAND);

endmodule

// File: tb/tb_aes_key_expand_last.sv
// Directed bench for aes_key_expand_last.
// Known FIPS-197 keys, disturbance, back-to-back and reset cases.
module tb_aes_key_expand_last;

   localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RA1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] RC1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] RZ  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] cipher_key = 128'h0;
   logic [127:0] round_key_10;
   logic         key_ready;
   logic         busy;

   int checks = 0;
   int errors = 0;

   aes_key_expand_last dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cipher_key   (cipher_key),
      .round_key_10 (round_key_10),
      .key_ready    (key_ready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_key(input string tag,
                          input logic [127:0] key,
                          input logic [127:0] exp);
      int busy_n;
      int kr_n;
      busy_n = 0;
      kr_n = 0;
      cipher_key = key;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (busy === 1'b1) busy_n++;
         if (key_ready !== 1'b0) kr_n++;
         tick();
      end
      chk({tag, "_early_ready"}, 128'(kr_n), 128'd0);
      chk({tag, "_busy_cycles"}, 128'(busy_n), 128'd10);
      chk({tag, "_ready"}, {127'h0, key_ready}, 128'd1);
      chk({tag, "_busy_done"}, {127'h0, busy}, 128'd0);
      chk({tag, "_key"}, round_key_10, exp);
      tick();
      chk({tag, "_ready_drop"}, {127'h0, key_ready}, 128'd0);
      chk({tag, "_key_hold"}, round_key_10, exp);
   endtask

   initial begin
      int kr_n;
      int bad;
      logic [127:0] exp_rk;
      logic         exp_kr;

      #1;
      chk("rst_key", round_key_10, 128'h0);
      chk("rst_ready", {127'h0, key_ready}, 128'd0);
      chk("rst_busy", {127'h0, busy}, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", {127'h0, busy}, 128'd0);

      run_key("a1", KA1, RA1);
      run_key("c1", KC1, RC1);
      run_key("zero", 128'h0, RZ);

      // start pulse and key change mid-expansion must be ignored
      cipher_key = KA1;
      start = 1'b1;
      tick();
      kr_n = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 4) begin
            start = 1'b1;
            cipher_key = KC1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (key_ready === 1'b1) kr_n++;
      end
      chk("dist_key", round_key_10, RA1);
      chk("dist_ready", {127'h0, key_ready}, 128'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (key_ready === 1'b1) kr_n++;
      end
      chk("dist_ready_count", 128'(kr_n), 128'd1);
      chk("dist_idle", {127'h0, busy}, 128'd0);

      // start held high: pulses at 10 and 21
      run_key("zero2", 128'h0, RZ);
      cipher_key = KA1;
      start = 1'b1;
      tick();
      cipher_key = KC1;
      bad = 0;
      for (int i = 1; i <= 21; i++) begin
         tick();
         exp_kr = (i == 10) || (i == 21);
         if (i < 10) exp_rk = RZ;
         else if (i < 21) exp_rk = RA1;
         else exp_rk = RC1;
         if (key_ready !== exp_kr) bad++;
         if (round_key_10 !== exp_rk) bad++;
         if (i == 11) chk("b2b_accept", {127'h0, busy}, 128'd1);
         if (i == 10) chk("b2b_key1", round_key_10, RA1);
      end
      start = 1'b0;
      chk("b2b_seq", 128'(bad), 128'd0);
      chk("b2b_key2", round_key_10, RC1);
      chk("b2b_ready2", {127'h0, key_ready}, 128'd1);
      tick();
      chk("b2b_drop", {127'h0, key_ready}, 128'd0);
      chk("b2b_idle", {127'h0, busy}, 128'd0);

      // asynchronous reset during round 6
      cipher_key = KA1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy", {127'h0, busy}, 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_key", round_key_10, 128'h0);
      chk("mid_rst_ready", {127'h0, key_ready}, 128'd0);
      chk("mid_rst_busy", {127'h0, busy}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (key_ready !== 1'b0) bad++;
         if (busy !== 1'b0) bad++;
         if (round_key_10 !== 128'h0) bad++;
      end
      chk("post_rst_quiet", 128'(bad), 128'd0);
      run_key("a1_again", KA1, RA1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
